// File: rtl/voxel_query_unit.sv
// Voxel occupancy query unit: accepts (x,y,z,tag) queries, reads a 1-bit
// occupancy from an external 2-cycle synchronous RAM, and returns
// {occupied, tag} in order through a 4-entry response FIFO. Credits cover
// both queued and in-flight requests so the FIFO can never overflow.
module voxel_query_unit #(
  parameter int X_BITS   = 5,
  parameter int Y_BITS   = 5,
  parameter int Z_BITS   = 5,
  parameter int TAG_BITS = 4,
  localparam int ADDR_BITS = X_BITS + Y_BITS + Z_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_mode,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [X_BITS-1:0]    req_x,
  input  logic [Y_BITS-1:0]    req_y,
  input  logic [Z_BITS-1:0]    req_z,
  input  logic [TAG_BITS-1:0]  req_tag,
  output logic [ADDR_BITS-1:0] ram_raddr,
  input  logic                 ram_rdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_occupied,
  output logic [TAG_BITS-1:0]  resp_tag,
  output logic [15:0]          query_count,
  output logic [15:0]          hit_count
);

  localparam int DEPTH = 4;

  // in-flight pipeline matching the RAM read latency
  logic                p1_valid;
  logic [TAG_BITS-1:0] p1_tag;
  logic                p2_valid;
  logic [TAG_BITS-1:0] p2_tag;

  // response FIFO
  logic                fifo_occ [DEPTH];
  logic [TAG_BITS-1:0] fifo_tag [DEPTH];
  logic [1:0]          wr_ptr;
  logic [1:0]          rd_ptr;
  logic [2:0]          fifo_count;

  logic [2:0] occupancy;
  logic       accept;
  logic       push;
  logic       pop;

  assign ram_raddr = {req_z, req_y, req_x};

  // Credits count registered FIFO entries plus in-flight requests only, so a
  // pop in the current cycle frees its slot one cycle later.
  assign occupancy = fifo_count + {2'b00, p1_valid} + {2'b00, p2_valid};
  assign req_ready = !load_mode && (occupancy < 3'(DEPTH));
  assign accept    = req_valid && req_ready;
  assign push      = p2_valid;

  assign resp_valid    = (fifo_count != 3'd0);
  assign pop           = resp_valid && resp_ready;
  assign resp_occupied = resp_valid ? fifo_occ[rd_ptr] : 1'b0;
  assign resp_tag      = resp_valid ? fifo_tag[rd_ptr] : '0;

  // advance requests through the two RAM-latency stages
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_valid <= 1'b0;
      p1_tag   <= '0;
      p2_valid <= 1'b0;
      p2_tag   <= '0;
    end else begin
      p1_valid <= accept;
      if (accept) p1_tag <= req_tag;
      p2_valid <= p1_valid;
      p2_tag   <= p1_tag;
    end
  end

  // FIFO storage write; contents are masked on the outputs while empty
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_occ[wr_ptr] <= ram_rdata;
      fifo_tag[wr_ptr] <= p2_tag;
    end
  end

  // FIFO pointers and entry count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // wrapping accept counter and saturating hit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      query_count <= '0;
      hit_count   <= '0;
    end else begin
      if (accept) query_count <= query_count + 16'd1;
      if (push && ram_rdata && (hit_count != '1)) hit_count <= hit_count + 16'd1;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (fifo_count == 3'(DEPTH))));

endmodule

// File: tb/tb_voxel_query_unit.sv
// Bench for voxel_query_unit: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_voxel_query_unit;

  localparam int XB = 5;
  localparam int YB = 5;
  localparam int ZB = 5;
  localparam int TB = 4;
  localparam int AB = XB + YB + ZB;

  logic          clk = 1'b0;
  logic          rst, load_mode, req_valid, resp_ready;
  logic          req_ready, resp_valid, resp_occupied;
  logic [XB-1:0] req_x;
  logic [YB-1:0] req_y;
  logic [ZB-1:0] req_z;
  logic [TB-1:0] req_tag, resp_tag;
  logic [AB-1:0] ram_raddr;
  logic          ram_q1 = 1'b0;
  logic          ram_rdata = 1'b0;
  logic [15:0]   query_count, hit_count;

  always #5 clk = ~clk;

  voxel_query_unit #(.X_BITS(XB), .Y_BITS(YB), .Z_BITS(ZB), .TAG_BITS(TB)) dut (
    .clk(clk), .rst(rst), .load_mode(load_mode),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_tag(req_tag),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_occupied(resp_occupied), .resp_tag(resp_tag),
    .query_count(query_count), .hit_count(hit_count)
  );

  // external voxel RAM, 2-cycle synchronous read
  bit mem [0:(1<<AB)-1];
  always @(posedge clk) begin
    ram_q1    <= mem[ram_raddr];
    ram_rdata <= ram_q1;
  end

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: outstanding requests with their age, and the response queue
  typedef struct { int age; bit occ; logic [TB-1:0] tag; } ent_t;
  ent_t        infl[$];
  ent_t        rq[$];
  int unsigned m_q = 0;
  int unsigned m_h = 0;

  function automatic bit m_ready();
    return !load_mode && ((infl.size() + rq.size()) < 4);
  endfunction

  always @(posedge clk) begin : model
    bit   acc, pop;
    ent_t e;
    if (rst) begin
      infl.delete(); rq.delete(); m_q = 0; m_h = 0;
    end else begin
      acc = req_valid && m_ready();
      pop = (rq.size() > 0) && resp_ready;
      if (pop) void'(rq.pop_front());
      if (infl.size() > 0 && infl[0].age == 1) begin
        e = infl.pop_front();
        rq.push_back(e);
        if (e.occ && m_h < 32'hFFFF) m_h++;
      end
      foreach (infl[i]) infl[i].age++;
      if (acc) begin
        e.age = 0; e.occ = mem[{req_z, req_y, req_x}]; e.tag = req_tag;
        infl.push_back(e);
        m_q = (m_q + 1) & 32'hFFFF;
      end
    end
  end

  // per-cycle comparison and response log
  bit            chk_en = 0;
  int unsigned   cyc = 0;
  int unsigned   rcyc[$];
  logic [TB-1:0] rtag[$];

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      check_eq("req_ready", 32'(req_ready), 32'(m_ready()));
      check_eq("resp_valid", 32'(resp_valid), 32'(rq.size() > 0));
      check_eq("resp_occupied", 32'(resp_occupied), rq.size() > 0 ? 32'(rq[0].occ) : 32'd0);
      check_eq("resp_tag", 32'(resp_tag), rq.size() > 0 ? 32'(rq[0].tag) : 32'd0);
      check_eq("query_count", 32'(query_count), m_q);
      check_eq("hit_count", 32'(hit_count), m_h);
      check_eq("ram_raddr", 32'(ram_raddr), 32'({req_z, req_y, req_x}));
      if (resp_valid && resp_ready) begin
        rcyc.push_back(cyc);
        rtag.push_back(resp_tag);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    rcyc.delete();
    rtag.delete();
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int unsigned nacc;
    rst = 1; load_mode = 0; req_valid = 0; resp_ready = 1;
    req_x = '0; req_y = '0; req_z = '0; req_tag = '0;
    step();
    chk_en = 1;
    step();
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_resp_occ", 32'(resp_occupied), 32'd0);
    check_eq("rst_resp_tag", 32'(resp_tag), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_counts", {query_count, hit_count}, 32'd0);
    load_mode = 1; #1;
    check_eq("rst_ready_load", 32'(req_ready), 32'd0);
    load_mode = 0;
    rst = 0;
    step();

    // single query
    mem[15'h0443] = 1'b1;
    req_x = 5'd3; req_y = 5'd2; req_z = 5'd1; req_tag = 4'd5; req_valid = 1;
    #1;
    check_eq("single_raddr", 32'(ram_raddr), 32'h0443);
    step();
    req_valid = 0;
    step();
    check_eq("single_lat_k1", 32'(resp_valid), 32'd0);
    step();
    check_eq("single_valid", 32'(resp_valid), 32'd1);
    check_eq("single_occ", 32'(resp_occupied), 32'd1);
    check_eq("single_tag", 32'(resp_tag), 32'd5);
    check_eq("single_hits", 32'(hit_count), 32'd1);
    check_eq("single_queries", 32'(query_count), 32'd1);
    step();

    // back-to-back stream
    clear_log();
    for (int i = 0; i < 8; i++) begin
      req_tag = 4'(i); req_x = 5'($urandom); req_y = 5'($urandom); req_z = 5'($urandom);
      req_valid = 1;
      check_eq("b2b_ready", 32'(req_ready), 32'd1);
      step();
    end
    req_valid = 0;
    repeat (6) step();
    check_eq("b2b_count", rtag.size(), 32'd8);
    for (int i = 0; i < 8 && i < rtag.size(); i++) begin
      check_eq("b2b_tag", 32'(rtag[i]), 32'(i));
      check_eq("b2b_cycle", rcyc[i], rcyc[0] + 32'(i));
    end

    // backpressure
    resp_ready = 0; nacc = 0;
    for (int i = 0; i < 8; i++) begin
      req_tag = 4'(i); req_valid = 1;
      if (req_ready) nacc++;
      step();
    end
    check_eq("bp_accepts", nacc, 32'd4);
    check_eq("bp_ready_low", 32'(req_ready), 32'd0);
    req_valid = 0;
    clear_log();
    resp_ready = 1;
    repeat (6) step();
    check_eq("bp_resp_count", rtag.size(), 32'd4);
    for (int i = 0; i < 4 && i < rtag.size(); i++) check_eq("bp_tag", 32'(rtag[i]), 32'(i));

    // load_mode rising behind an accept
    clear_log();
    req_tag = 4'd9; req_valid = 1;
    step();
    req_valid = 0; load_mode = 1; #1;
    check_eq("load_ready", 32'(req_ready), 32'd0);
    repeat (4) step();
    check_eq("load_resp_count", rtag.size(), 32'd1);
    if (rtag.size() > 0) check_eq("load_resp_tag", 32'(rtag[0]), 32'd9);
    load_mode = 0;
    step();

    // reset with 2 queued and 2 in flight
    resp_ready = 0;
    for (int i = 1; i <= 4; i++) begin
      req_tag = 4'(i); req_valid = 1;
      step();
    end
    req_valid = 0;
    check_eq("mid_queued", 32'(resp_valid), 32'd1);
    rst = 1;
    step();
    check_eq("mid_rst_valid", 32'(resp_valid), 32'd0);
    check_eq("mid_rst_tag", 32'(resp_tag), 32'd0);
    check_eq("mid_rst_counts", {query_count, hit_count}, 32'd0);
    rst = 0; resp_ready = 1;
    clear_log();
    repeat (6) step();
    check_eq("mid_no_stale", rtag.size(), 32'd0);

    // randomized traffic
    for (int unsigned i = 0; i < (1 << AB); i++) mem[i] = 1'($urandom);
    for (int i = 0; i < 2000; i++) begin
      req_valid  = ($urandom_range(0, 9) < 7);
      resp_ready = ($urandom_range(0, 9) < 6);
      load_mode  = ($urandom_range(0, 9) == 0);
      rst        = ($urandom_range(0, 99) == 0);
      req_x = 5'($urandom); req_y = 5'($urandom); req_z = 5'($urandom); req_tag = 4'($urandom);
      step();
    end
    rst = 0; req_valid = 0; load_mode = 0; resp_ready = 1;
    repeat (8) step();

    // counter saturation and wrap
    rst = 1; step(); rst = 0;
    for (int unsigned i = 0; i < (1 << AB); i++) mem[i] = 1'b1;
    req_valid = 1;
    repeat (65534) step();
    req_valid = 0;
    repeat (4) step();
    check_eq("cnt_hit_fffe", 32'(hit_count), 32'hFFFE);
    check_eq("cnt_q_fffe", 32'(query_count), 32'hFFFE);
    req_valid = 1;
    repeat (2) step();
    check_eq("cnt_q_wrap", 32'(query_count), 32'd0);
    step();
    req_valid = 0;
    repeat (4) step();
    check_eq("cnt_hit_sat", 32'(hit_count), 32'hFFFF);
    check_eq("cnt_q_after", 32'(query_count), 32'd1);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/voxel_query_unit.md
VOXEL_QUERY_UNIT -- requirements
Module: voxel_query_unit

Interface
REQ-001 The block SHALL have parameter X_BITS, default 5, meaning x coordinate width.
REQ-002 The block SHALL have parameter Y_BITS, default 5, meaning y coordinate width.
REQ-003 The block SHALL have parameter Z_BITS, default 5, meaning z coordinate width.
REQ-004 The block SHALL have parameter TAG_BITS, default 4, meaning width of the opaque request tag returned with each response.
REQ-005 The block SHALL derive localparam ADDR_BITS = X_BITS+Y_BITS+Z_BITS.
REQ-006 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous active-high reset.
- load_mode  in  1  scene loading in progress; new queries are blocked while high.
- req_valid  in  1  query request valid.
- req_ready  out  1  query request accepted when high together with req_valid.
- req_x  in  X_BITS  voxel x.
- req_y  in  Y_BITS  voxel y.
- req_z  in  Z_BITS  voxel z.
- req_tag  in  TAG_BITS  request tag.
- ram_raddr  out  ADDR_BITS  voxel RAM read address.
- ram_rdata  in  1  voxel RAM read data (synchronous RAM, 2-cycle read latency).
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumed when high together with resp_valid.
- resp_occupied  out  1  occupancy bit of the queried voxel.
- resp_tag  out  TAG_BITS  tag of the queried voxel.
- query_count  out  16  accepted queries, wrapping.
- hit_count  out  16  occupied responses, saturating.

Function
REQ-007 ram_raddr SHALL be combinational {req_z, req_y, req_x}, driven every cycle regardless of req_valid.
REQ-008 A request SHALL be accepted at a rising edge where req_valid && req_ready.
REQ-009 req_ready SHALL be !load_mode && (occ < 4), where occ = FIFO count + in-flight count, using registered values only; a same-cycle pop SHALL NOT raise req_ready.
REQ-010 An accepted request SHALL enter in-flight stage P1 (valid, tag) at edge k, move to stage P2 at edge k+1, and push {ram_rdata, tag} into the response FIFO at edge k+2.
REQ-011 The response FIFO SHALL hold 4 entries, deliver them in order, and present its head combinationally on resp_occupied and resp_tag.
REQ-012 resp_valid SHALL be high iff the FIFO is non-empty; the earliest resp_valid is the cycle after edge k+2, with no bypass path.
REQ-013 The FIFO SHALL support a simultaneous push and pop in one cycle, including when the count is 4 before the pop and when the count is 0 before the push.
REQ-014 The FIFO SHALL never overflow; the credit rule in REQ-009 guarantees this, and an overflow is a design error flagged by a simulation assertion.
REQ-015 Back-to-back accepts SHALL be possible every cycle while resp_ready stays high, giving throughput of 1 query per cycle.
REQ-016 When load_mode rises, in-flight requests SHALL still complete and push; only new accepts are blocked.
REQ-017 query_count SHALL increment by 1 on each accept and wrap from 0xFFFF to 0.
REQ-018 hit_count SHALL increment by 1 on each push with occupied=1 and hold at 0xFFFF.
REQ-019 When req_valid is high and req_ready is low, the request SHALL not be accepted and no in-flight or counter state SHALL change.

Reset
REQ-020 When rst is high at a rising edge, P1, P2, FIFO pointers, FIFO count, query_count and hit_count SHALL clear to 0.
REQ-021 During and immediately after reset: resp_valid=0, resp_occupied=0, resp_tag=0, and req_ready = !load_mode.
REQ-022 Reset asserted mid-operation SHALL discard all in-flight requests and queued responses; no response for them SHALL appear after reset.

Verification
REQ-023 Single query: RAM preloaded with voxel (3,2,1)=1; query x=3,y=2,z=1,tag=5 accepted at edge k -> ram_raddr=0x0443; resp_valid first high after edge k+2 with occupied=1, tag=5; hit_count=1, query_count=1.
REQ-024 Back-to-back stream: 8 consecutive queries with tags 0..7 and resp_ready=1 -> req_ready stays 1, responses arrive in tag order 0..7 on 8 consecutive cycles.
REQ-025 Backpressure: resp_ready=0 with continuous req_valid -> exactly 4 accepts, then req_ready=0; after resp_ready=1 the 4 responses arrive in order, with no loss and no duplicates.
REQ-026 load_mode rises 1 cycle after an accept -> req_ready=0 immediately, and the in-flight response still arrives with the correct tag.
REQ-027 rst pulsed while 2 requests are in flight and 2 responses are queued -> all outputs clear and no stale resp_valid appears afterwards.
REQ-028 Counters: force hit_count to 0xFFFE, then 3 occupied responses -> hit_count=0xFFFF; 65536 accepts -> query_count returns to its start value.
